// File: rtl/axi2mem_pkg.sv
// Shared types and constants for the axi2mem read/write command arbiter.
package axi2mem_pkg;

    localparam int unsigned CMD_ADDR_WIDTH = 32;
    localparam int unsigned CMD_ID_WIDTH   = 6;
    localparam int unsigned NUM_LANES      = 2;

    // Arbiter state: free, or locked to one channel until its last beat is accepted
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK_RD = 2'd1,
        LOCK_WR = 2'd2
    } arb_state_e;

    localparam logic OWN_RD = 1'b0;
    localparam logic OWN_WR = 1'b1;

    // One 64-bit beat as presented on the two 32-bit command lanes
    typedef struct packed {
        logic [NUM_LANES-1:0]                     req;
        logic [NUM_LANES-1:0][CMD_ADDR_WIDTH-1:0] add;
        logic [NUM_LANES-1:0][CMD_ID_WIDTH-1:0]   id;
        logic [NUM_LANES-1:0]                     last;
    } trans_cmd_t;

    // True when the two lanes disagree (01 or 10)
    function automatic logic lanes_split(input logic [NUM_LANES-1:0] v);
        return v[0] ^ v[1];
    endfunction

endpackage

// File: rtl/axi2mem_trans_arbiter.sv
// Burst-granular round-robin arbiter sharing the two-lane TCDM command queue
// between the axi2mem read and write channels. Command path is combinational.
module axi2mem_trans_arbiter
    import axi2mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CMD_ADDR_WIDTH,
    parameter int unsigned ID_WIDTH   = CMD_ID_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic [1:0]                rd_req_i,
    input  logic [1:0][ADDR_WIDTH-1:0] rd_add_i,
    input  logic [1:0][ID_WIDTH-1:0]   rd_id_i,
    input  logic [1:0]                rd_last_i,
    output logic [1:0]                rd_gnt_o,

    input  logic [1:0]                wr_req_i,
    input  logic [1:0][ADDR_WIDTH-1:0] wr_add_i,
    input  logic [1:0][ID_WIDTH-1:0]   wr_id_i,
    input  logic [1:0]                wr_last_i,
    output logic [1:0]                wr_gnt_o,

    output logic [1:0]                cmd_req_o,
    output logic [1:0][ADDR_WIDTH-1:0] cmd_add_o,
    output logic [1:0][ID_WIDTH-1:0]   cmd_id_o,
    output logic [1:0]                cmd_last_o,
    output logic                      cmd_we_o,
    input  logic [1:0]                cmd_gnt_i,

    output logic                      busy_o,
    output logic                      owner_o,
    output logic                      err_o
);

    arb_state_e state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       err_q, err_d;

    logic       sel;
    logic [1:0] sel_req;
    logic [1:0] sel_last;
    logic       gnt_all;
    logic       req_split;
    logic       accept;
    logic       last_all;
    logic       last_bad;

    // Selected requester: pointer while free, owner while locked
    always_comb begin
        sel       = ptr_q;
        if (state_q == LOCK_RD) sel = OWN_RD;
        if (state_q == LOCK_WR) sel = OWN_WR;
        sel_req   = (sel == OWN_WR) ? wr_req_i  : rd_req_i;
        sel_last  = (sel == OWN_WR) ? wr_last_i : rd_last_i;
        gnt_all   = (cmd_gnt_i == 2'b11);
        req_split = lanes_split(sel_req);
        accept    = (sel_req == 2'b11) && gnt_all;
        last_all  = (sel_last == 2'b11);
        last_bad  = lanes_split(sel_last);
    end

    // State, round-robin pointer and sticky error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= OWN_RD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    // Next state: hold lock until the owner's last beat is accepted
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        err_d   = err_q | req_split | (accept & last_bad);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (last_all) begin
                        ptr_d = ~sel;
                    end else begin
                        state_d = (sel == OWN_WR) ? LOCK_WR : LOCK_RD;
                    end
                end else if (sel_req == 2'b00) begin
                    // Pointer faces a silent requester: offer to the other side
                    ptr_d = ~ptr_q;
                end
            end
            LOCK_RD, LOCK_WR: begin
                if (accept && last_all) begin
                    state_d = IDLE;
                    ptr_d   = ~sel;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = OWN_RD;
            end
        endcase
    end

    // Grants and forwarded command; lanes are only ever granted together
    always_comb begin
        rd_gnt_o   = 2'b00;
        wr_gnt_o   = 2'b00;
        if (gnt_all) begin
            if (sel == OWN_WR) wr_gnt_o = 2'b11;
            else               rd_gnt_o = 2'b11;
        end
        // A lane-split request never reaches the queue
        cmd_req_o  = (accept) ? 2'b11 : 2'b00;
        cmd_add_o  = (sel == OWN_WR) ? wr_add_i : rd_add_i;
        cmd_id_o   = (sel == OWN_WR) ? wr_id_i  : rd_id_i;
        cmd_last_o = sel_last;
        cmd_we_o   = (sel == OWN_WR);
        busy_o     = (state_q != IDLE);
        owner_o    = sel;
        err_o      = err_q;
    end

endmodule

// File: tb/tb_axi2mem_trans_arbiter.sv
// Scoreboard bench for axi2mem_trans_arbiter: directed cycle vectors push their
// hand-computed expected outputs; a monitor pops and compares on the falling edge.
module tb_axi2mem_trans_arbiter;

    logic                clk;
    logic                rst_n;
    logic [1:0]          rd_req, rd_last, rd_gnt;
    logic [1:0][31:0]    rd_add;
    logic [1:0][5:0]     rd_id;
    logic [1:0]          wr_req, wr_last, wr_gnt;
    logic [1:0][31:0]    wr_add;
    logic [1:0][5:0]     wr_id;
    logic [1:0]          cmd_req, cmd_last, cmd_gnt;
    logic [1:0][31:0]    cmd_add;
    logic [1:0][5:0]     cmd_id;
    logic                cmd_we, busy, owner, err;

    typedef struct {
        logic [1:0]  rg;
        logic [1:0]  wg;
        logic [1:0]  cr;
        logic        we;
        logic [31:0] add;
        logic [1:0]  last;
        logic        busy;
        logic        own;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   row      = 0;

    axi2mem_trans_arbiter #(.ADDR_WIDTH(32), .ID_WIDTH(6)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rd_req_i   (rd_req),
        .rd_add_i   (rd_add),
        .rd_id_i    (rd_id),
        .rd_last_i  (rd_last),
        .rd_gnt_o   (rd_gnt),
        .wr_req_i   (wr_req),
        .wr_add_i   (wr_add),
        .wr_id_i    (wr_id),
        .wr_last_i  (wr_last),
        .wr_gnt_o   (wr_gnt),
        .cmd_req_o  (cmd_req),
        .cmd_add_o  (cmd_add),
        .cmd_id_o   (cmd_id),
        .cmd_last_o (cmd_last),
        .cmd_we_o   (cmd_we),
        .cmd_gnt_i  (cmd_gnt),
        .busy_o     (busy),
        .owner_o    (owner),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int r, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL row %0d %s: got %h expected %h", r, name, act, expv);
        end
    endtask

    // Monitor: compare every presented cycle against the oldest expectation
    initial begin
        exp_t e;
        int   r;
        r = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_gnt",   r, 32'(rd_gnt),     32'(e.rg));
                chk("wr_gnt",   r, 32'(wr_gnt),     32'(e.wg));
                chk("cmd_req",  r, 32'(cmd_req),    32'(e.cr));
                chk("cmd_we",   r, 32'(cmd_we),     32'(e.we));
                chk("cmd_add0", r, cmd_add[0],      e.add);
                chk("cmd_add1", r, cmd_add[1],      e.add + 32'd4);
                chk("cmd_id0",  r, 32'(cmd_id[0]),  e.we ? 32'h11 : 32'h01);
                chk("cmd_id1",  r, 32'(cmd_id[1]),  e.we ? 32'h12 : 32'h02);
                chk("cmd_last", r, 32'(cmd_last),   32'(e.last));
                chk("busy",     r, 32'(busy),       32'(e.busy));
                chk("owner",    r, 32'(owner),      32'(e.own));
                chk("err",      r, 32'(err),        32'(e.err));
                r++;
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue its expected outputs
    task automatic step(input logic rst, input logic [1:0] rq, input logic [1:0] rl,
                        input logic [1:0] wq, input logic [1:0] wl, input logic [1:0] cg,
                        input logic [31:0] ra, input logic [31:0] wa,
                        input logic [1:0] erg, input logic [1:0] ewg, input logic [1:0] ecr,
                        input logic ewe, input logic [31:0] eadd, input logic [1:0] elast,
                        input logic eb, input logic eo, input logic ee);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rst;
        rd_req    = rq;
        rd_last   = rl;
        wr_req    = wq;
        wr_last   = wl;
        cmd_gnt   = cg;
        rd_add[0] = ra;
        rd_add[1] = ra + 32'd4;
        wr_add[0] = wa;
        wr_add[1] = wa + 32'd4;
        e.rg = erg; e.wg = ewg; e.cr = ecr; e.we = ewe; e.add = eadd;
        e.last = elast; e.busy = eb; e.own = eo; e.err = ee;
        exp_q.push_back(e);
        row++;
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_req   = 2'b00; rd_last = 2'b00; rd_add = '0;
        wr_req   = 2'b00; wr_last = 2'b00; wr_add = '0;
        cmd_gnt  = 2'b00;
        rd_id[0] = 6'h01; rd_id[1] = 6'h02;
        wr_id[0] = 6'h11; wr_id[1] = 6'h12;

        //   rst rq     rl     wq     wl     cg     ra        wa          rg     wg     cr     we  add        last   b  o  e
        // Reset with all lanes free: read side offered, nothing forwarded
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 32'h100, 32'h200,   2'b11, 2'b00, 2'b00, 0, 32'h100, 2'b00, 0, 0, 0);
        // Silent requesters: grant alternates every cycle
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 32'h100, 32'h200,   2'b11, 2'b00, 2'b00, 0, 32'h100, 2'b00, 0, 0, 0);
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 32'h100, 32'h200,   2'b00, 2'b11, 2'b00, 1, 32'h200, 2'b00, 0, 1, 0);
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 32'h100, 32'h200,   2'b11, 2'b00, 2'b00, 0, 32'h100, 2'b00, 0, 0, 0);
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 32'h100, 32'h200,   2'b00, 2'b11, 2'b00, 1, 32'h200, 2'b00, 0, 1, 0);
        // Single-beat read forwarded in the same cycle; pointer moves to WR
        step(1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 32'h100, 32'h200,   2'b11, 2'b00, 2'b11, 0, 32'h100, 2'b11, 0, 0, 0);
        // Four-beat write burst with read requesting throughout
        step(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 32'h100, 32'h200,   2'b00, 2'b11, 2'b11, 1, 32'h200, 2'b00, 0, 1, 0);
        step(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 32'h100, 32'h208,   2'b00, 2'b11, 2'b11, 1, 32'h208, 2'b00, 1, 1, 0);
        // Queue can take only one lane: burst stalls, nothing forwarded
        step(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 32'h100, 32'h210,   2'b00, 2'b00, 2'b00, 1, 32'h210, 2'b00, 1, 1, 0);
        step(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 32'h100, 32'h210,   2'b00, 2'b11, 2'b11, 1, 32'h210, 2'b00, 1, 1, 0);
        step(1, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 32'h100, 32'h218,   2'b00, 2'b11, 2'b11, 1, 32'h218, 2'b11, 1, 1, 0);
        // Waiting read forwarded right after the last write beat
        step(1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 32'h100, 32'h220,   2'b11, 2'b00, 2'b11, 0, 32'h100, 2'b11, 0, 0, 0);
        // Lane-split write request: not forwarded, pointer held, error next cycle
        step(1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 32'h100, 32'h220,   2'b00, 2'b11, 2'b00, 1, 32'h220, 2'b00, 0, 1, 0);
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 32'h100, 32'h220,   2'b00, 2'b11, 2'b00, 1, 32'h220, 2'b00, 0, 1, 1);
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 32'h100, 32'h220,   2'b11, 2'b00, 2'b00, 0, 32'h100, 2'b00, 0, 0, 1);
        // Write burst interrupted by reset on its third cycle
        step(1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 32'h100, 32'h300,   2'b00, 2'b11, 2'b11, 1, 32'h300, 2'b00, 0, 1, 1);
        step(1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 32'h100, 32'h308,   2'b00, 2'b11, 2'b11, 1, 32'h308, 2'b00, 1, 1, 1);
        step(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 32'h100, 32'h310,   2'b11, 2'b00, 2'b00, 0, 32'h100, 2'b00, 0, 0, 0);
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 32'h100, 32'h310,   2'b11, 2'b00, 2'b00, 0, 32'h100, 2'b00, 0, 0, 0);
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 32'h100, 32'h310,   2'b00, 2'b11, 2'b00, 1, 32'h310, 2'b00, 0, 1, 0);
        // Read waiting on a partial queue grant keeps the pointer, then goes through
        step(1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b10, 32'h100, 32'h310,   2'b00, 2'b00, 2'b00, 0, 32'h100, 2'b11, 0, 0, 0);
        step(1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 32'h100, 32'h310,   2'b11, 2'b00, 2'b11, 0, 32'h100, 2'b11, 0, 0, 0);
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 32'h100, 32'h310,   2'b00, 2'b11, 2'b00, 1, 32'h310, 2'b00, 0, 1, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
